// File: rtl/csa_word_sequencer_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
// CSA_SEQ_SUB_EN (optional) adds a subtract request bit.
package csa_seq_pkg;

  localparam int SLICE_W   = 8;
  localparam int WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csa_word_sequencer_if.sv
// Request/response handshake bundle for csa_word_sequencer.
// CSA_SEQ_SUB_EN adds the sub request bit.
interface csa_word_sequencer_if
  import csa_seq_pkg::*;
#(
  parameter int WORDS = WORDS_DEF
);

  localparam int W = WORDS * SLICE_W;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
`ifdef CSA_SEQ_SUB_EN
  logic         sub;
`endif
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] sum_out;
  logic         cout;

`ifdef CSA_SEQ_SUB_EN
  modport master (
    output req_valid, a_in, b_in, cin, sub,
    output rsp_ready,
    input  req_ready, rsp_valid, sum_out, cout
  );
  modport slave (
    input  req_valid, a_in, b_in, cin, sub,
    input  rsp_ready,
    output req_ready, rsp_valid, sum_out, cout
  );
`else
  modport master (
    output req_valid, a_in, b_in, cin,
    output rsp_ready,
    input  req_ready, rsp_valid, sum_out, cout
  );
  modport slave (
    input  req_valid, a_in, b_in, cin,
    input  rsp_ready,
    output req_ready, rsp_valid, sum_out, cout
  );
`endif

endinterface

// File: rtl/csa_word_sequencer.sv
// Byte-serial multi-precision adder driving an external 8-bit slice.
// CSA_SEQ_SUB_EN enables A-B via inverted B and forced carry-in.
module csa_word_sequencer
  import csa_seq_pkg::*;
#(
  parameter int WORDS = WORDS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  csa_word_sequencer_if.slave bus,
  output logic [SLICE_W-1:0] add_a,
  output logic [SLICE_W-1:0] add_b,
  output logic               add_cin,
  input  logic [SLICE_W-1:0] add_sum,
  input  logic               add_cout
);

  localparam int W  = WORDS * SLICE_W;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  sum_r;
  logic          carry_r;
  logic          cout_r;
  logic          rsp_valid_r;
  logic [W-1:0]  b_cap;
  logic          c_cap;

  // Subtraction is A + ~B + 1, so only the captured operands change
  always_comb begin
    b_cap = bus.b_in;
    c_cap = bus.cin;
`ifdef CSA_SEQ_SUB_EN
    if (bus.sub) begin
      b_cap = ~bus.b_in;
      c_cap = 1'b1;
    end
`endif
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.sum_out   = sum_r;
  assign bus.cout      = cout_r;

  assign add_a   = (state == RUN) ? a_r[idx*SLICE_W +: SLICE_W] : '0;
  assign add_b   = (state == RUN) ? b_r[idx*SLICE_W +: SLICE_W] : '0;
  assign add_cin = (state == RUN) ? carry_r : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_r     <= bus.a_in;
            b_r     <= b_cap;
            carry_r <= c_cap;
            idx     <= '0;
            sum_r   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_r[idx*SLICE_W +: SLICE_W] <= add_sum;
          carry_r <= add_cout;
          if (idx == LAST) begin
            cout_r      <= add_cout;
            idx         <= '0;
            rsp_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_word_sequencer.sv
// Directed bench for csa_word_sequencer with a behavioural 8-bit slice.
// Define CSA_SEQ_SUB_EN to also run the subtract vectors.
module tb_csa_word_sequencer;
  import csa_seq_pkg::*;

  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_word_sequencer_if #(.WORDS(WORDS)) bus ();

  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;

  assign {add_cout, add_sum} =
    {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  csa_word_sequencer #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  int checks   = 0;
  int failures = 0;
  int edges;
  logic [3:0] cmask;
  logic seen;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic c);
    bus.a_in      = a;
    bus.b_in      = b;
    bus.cin       = c;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // edges counts clock edges from the accepting edge inclusive
  task automatic collect();
    edges = 1;
    cmask = '0;
    while (bus.rsp_valid !== 1'b1 && edges < 20) begin
      if (edges <= 4) cmask[edges-1] = add_cin;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.cin       = 1'b0;
`ifdef CSA_SEQ_SUB_EN
    bus.sub       = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_sum", 64'(bus.sum_out), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    chk("rst_add", 64'({add_a, add_b, add_cin}), 64'd0);

    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    collect();
    chk("t1_latency", 64'(edges), 64'd5);
    chk("t1_sum", 64'(bus.sum_out), 64'h0000_0100);
    chk("t1_cout", 64'(bus.cout), 64'd0);
    chk("t1_cinmask", 64'(cmask), 64'b0010);
    release_rsp();
    chk("t1_rel_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t1_rel_ready", 64'(bus.req_ready), 64'd1);

    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    collect();
    chk("t2_sum", 64'(bus.sum_out), 64'h0000_0000);
    chk("t2_cout", 64'(bus.cout), 64'd1);
    chk("t2_cinmask", 64'(cmask), 64'b1110);
    release_rsp();
    chk("t2_idle_add", 64'({add_a, add_b, add_cin}), 64'd0);

    send(32'h0, 32'h0, 1'b1);
    bus.a_in = 32'hDEAD_BEEF;
    bus.b_in = 32'hFFFF_FFFF;
    collect();
    chk("t3_sum", 64'(bus.sum_out), 64'h0000_0001);
    chk("t3_cout", 64'(bus.cout), 64'd0);
    chk("t3_cinmask", 64'(cmask), 64'b0001);
    release_rsp();

    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    collect();
    chk("t4_sum", 64'(bus.sum_out), 64'h2345_6789);
    bus.a_in      = 32'h8000_0000;
    bus.b_in      = 32'h8000_0000;
    bus.cin       = 1'b1;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("t4_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t4_hold_ready", 64'(bus.req_ready), 64'd0);
      chk("t4_hold_sum", 64'(bus.sum_out), 64'h2345_6789);
      chk("t4_hold_cout", 64'(bus.cout), 64'd0);
    end
    release_rsp();
    chk("t4_rel_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t4_rel_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("t4_accepted", 64'(bus.req_ready), 64'd0);
    collect();
    chk("t4b_latency", 64'(edges), 64'd5);
    chk("t4b_sum", 64'(bus.sum_out), 64'h0000_0001);
    chk("t4b_cout", 64'(bus.cout), 64'd1);
    release_rsp();

    send(32'h0101_0101, 32'h0101_0101, 1'b0);
    @(posedge clk);
    #1;
    chk("t5_partial", 64'(bus.sum_out), 64'h0000_0002);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_req_ready", 64'(bus.req_ready), 64'd1);
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t5_sum", 64'(bus.sum_out), 64'd0);
    chk("t5_cout", 64'(bus.cout), 64'd0);
    chk("t5_add", 64'({add_a, add_b, add_cin}), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    chk("t5_no_rsp", 64'(seen), 64'd0);

`ifdef CSA_SEQ_SUB_EN
    bus.sub = 1'b1;
    send(32'd5, 32'd7, 1'b0);
    collect();
    chk("sub1_sum", 64'(bus.sum_out), 64'hFFFF_FFFE);
    chk("sub1_cout", 64'(bus.cout), 64'd0);
    release_rsp();
    send(32'd7, 32'd5, 1'b0);
    collect();
    chk("sub2_sum", 64'(bus.sum_out), 64'h0000_0002);
    chk("sub2_cout", 64'(bus.cout), 64'd1);
    release_rsp();
    bus.sub = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
